// File: rtl/rl_lj_pair_sequencer.sv
// Pair sweep controller for the range-limited LJ force pipeline: walks every
// (reference, neighbor) BRAM address pair, tags pairs for the pipeline, then drains.
module rl_lj_pair_sequencer #(
    parameter int REF_PARTICLE_NUM        = 10,
    parameter int REF_RAM_ADDR_WIDTH      = 4,
    parameter int NEIGHBOR_PARTICLE_NUM   = 10,
    parameter int NEIGHBOR_RAM_ADDR_WIDTH = 4,
    parameter int PIPE_LATENCY            = 14,
    parameter int LAT_CNT_WIDTH           = 5
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               pipe_ready,
    output logic [REF_RAM_ADDR_WIDTH-1:0]      ref_addr,
    output logic                               ref_rden,
    output logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] nb_addr,
    output logic                               nb_rden,
    output logic                               pair_valid,
    output logic                               pair_last_nb,
    output logic [REF_RAM_ADDR_WIDTH-1:0]      pair_ref_id,
    output logic                               busy,
    output logic                               done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [REF_RAM_ADDR_WIDTH-1:0] REF_LAST =
        REF_RAM_ADDR_WIDTH'(REF_PARTICLE_NUM - 1);
    localparam logic [NEIGHBOR_RAM_ADDR_WIDTH-1:0] NB_LAST =
        NEIGHBOR_RAM_ADDR_WIDTH'(NEIGHBOR_PARTICLE_NUM - 1);
    localparam logic [LAT_CNT_WIDTH-1:0] LAT_LAST =
        LAT_CNT_WIDTH'(PIPE_LATENCY - 1);

    state_t                     state;
    state_t                     state_next;
    logic                       rden;
    logic                       ref_at_last;
    logic                       nb_at_last;
    logic                       lat_at_last;
    logic [LAT_CNT_WIDTH-1:0]   lat_cnt;

    assign ref_at_last = (ref_addr == REF_LAST);
    assign nb_at_last  = (nb_addr == NB_LAST);
    assign lat_at_last = (lat_cnt == LAT_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rden       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                rden = pipe_ready;
                if (pipe_ready && ref_at_last && nb_at_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (lat_at_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        ref_rden = rden;
        nb_rden  = rden;
    end

    // Addresses sit at zero in IDLE so every sweep starts at (0,0); the final
    // read wraps both counters so they never leave the 0..NUM-1 range.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ref_addr <= '0;
            nb_addr  <= '0;
        end else if (state == IDLE) begin
            ref_addr <= '0;
            nb_addr  <= '0;
        end else if (rden) begin
            if (nb_at_last) begin
                nb_addr  <= '0;
                ref_addr <= ref_at_last ? '0 : ref_addr + 1'b1;
            end else begin
                nb_addr <= nb_addr + 1'b1;
            end
        end
    end

    // Held at zero outside DRAIN, so it is already cleared on entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_cnt <= '0;
        end else if (state != DRAIN) begin
            lat_cnt <= '0;
        end else begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pair_valid   <= 1'b0;
            pair_last_nb <= 1'b0;
            pair_ref_id  <= '0;
        end else begin
            pair_valid   <= rden;
            pair_last_nb <= rden && nb_at_last;
            if (rden) begin
                pair_ref_id <= ref_addr;
            end
        end
    end

endmodule

// File: tb/tb_rl_lj_pair_sequencer.sv
// Directed bench for rl_lj_pair_sequencer: default 10x10 sweep, stalls, mid-sweep
// reset, start pulse, 1x1 degenerate sweep and a 10x3 sweep with toggling ready.
module tb_rl_lj_pair_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut0: default 10x10, latency 14
    logic       rst0 = 1'b0, start0 = 1'b0, ready0 = 1'b1;
    logic [3:0] ref_addr0, nb_addr0, pair_ref_id0;
    logic       ref_rden0, nb_rden0, pair_valid0, pair_last_nb0, busy0, done0;

    // dut1: 1x1, latency 1
    logic       rst1 = 1'b0, start1 = 1'b0, ready1 = 1'b1;
    logic [3:0] ref_addr1, nb_addr1, pair_ref_id1;
    logic       ref_rden1, nb_rden1, pair_valid1, pair_last_nb1, busy1, done1;

    // dut2: 10x3, latency 14
    logic       rst2 = 1'b0, start2 = 1'b0, ready2 = 1'b1;
    logic [3:0] ref_addr2, nb_addr2, pair_ref_id2;
    logic       ref_rden2, nb_rden2, pair_valid2, pair_last_nb2, busy2, done2;

    rl_lj_pair_sequencer dut0 (
        .clk(clk), .rst(rst0), .start(start0), .pipe_ready(ready0),
        .ref_addr(ref_addr0), .ref_rden(ref_rden0), .nb_addr(nb_addr0), .nb_rden(nb_rden0),
        .pair_valid(pair_valid0), .pair_last_nb(pair_last_nb0), .pair_ref_id(pair_ref_id0),
        .busy(busy0), .done(done0)
    );

    rl_lj_pair_sequencer #(
        .REF_PARTICLE_NUM(1), .REF_RAM_ADDR_WIDTH(4),
        .NEIGHBOR_PARTICLE_NUM(1), .NEIGHBOR_RAM_ADDR_WIDTH(4),
        .PIPE_LATENCY(1), .LAT_CNT_WIDTH(5)
    ) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .pipe_ready(ready1),
        .ref_addr(ref_addr1), .ref_rden(ref_rden1), .nb_addr(nb_addr1), .nb_rden(nb_rden1),
        .pair_valid(pair_valid1), .pair_last_nb(pair_last_nb1), .pair_ref_id(pair_ref_id1),
        .busy(busy1), .done(done1)
    );

    rl_lj_pair_sequencer #(
        .REF_PARTICLE_NUM(10), .REF_RAM_ADDR_WIDTH(4),
        .NEIGHBOR_PARTICLE_NUM(3), .NEIGHBOR_RAM_ADDR_WIDTH(4),
        .PIPE_LATENCY(14), .LAT_CNT_WIDTH(5)
    ) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .pipe_ready(ready2),
        .ref_addr(ref_addr2), .ref_rden(ref_rden2), .nb_addr(nb_addr2), .nb_rden(nb_rden2),
        .pair_valid(pair_valid2), .pair_last_nb(pair_last_nb2), .pair_ref_id(pair_ref_id2),
        .busy(busy2), .done(done2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Values seen just after edge n are what edge n+1 samples, so "done after
    // edge T0+114" corresponds to done sampled at T0+115.
    task automatic run_sweep0(input string nm, input int stall_lo, input int stall_hi,
                              input int abort_at, input bit hold_start, input int exp_done);
        int k = 0;
        int c = 0;
        start0 = 1'b1;
        tick();
        if (!hold_start) start0 = 1'b0;
        while (k < 100 && c < 1000) begin
            ready0 = (c >= stall_lo && c <= stall_hi) ? 1'b0 : 1'b1;
            #1;
            chk({nm, "_ref_rden"}, 32'(ref_rden0), 32'(ready0));
            chk({nm, "_nb_rden"}, 32'(nb_rden0), 32'(ready0));
            chk({nm, "_ref_addr"}, 32'(ref_addr0), k / 10);
            chk({nm, "_nb_addr"}, 32'(nb_addr0), k % 10);
            if (k == abort_at) begin
                rst0 = 1'b0;
                tick();
                chk({nm, "_rst_pv"}, 32'(pair_valid0), 0);
                chk({nm, "_rst_last"}, 32'(pair_last_nb0), 0);
                chk({nm, "_rst_id"}, 32'(pair_ref_id0), 0);
                chk({nm, "_rst_rden"}, 32'(ref_rden0 | nb_rden0), 0);
                chk({nm, "_rst_addr"}, 32'({ref_addr0, nb_addr0}), 0);
                chk({nm, "_rst_busy"}, 32'(busy0), 0);
                chk({nm, "_rst_done"}, 32'(done0), 0);
                rst0 = 1'b1;
                tick();
                chk({nm, "_post_rst_pv"}, 32'(pair_valid0), 0);
                chk({nm, "_post_rst_busy"}, 32'(busy0), 0);
                return;
            end
            tick();
            c++;
            chk({nm, "_pair_valid"}, 32'(pair_valid0), 32'(ready0));
            if (ready0) begin
                chk({nm, "_pair_ref_id"}, 32'(pair_ref_id0), k / 10);
                chk({nm, "_pair_last_nb"}, 32'(pair_last_nb0), (k % 10 == 9) ? 1 : 0);
                k++;
            end else if (k > 0) begin
                chk({nm, "_ref_id_hold"}, 32'(pair_ref_id0), (k - 1) / 10);
            end
        end
        chk({nm, "_pair_count"}, k, 100);
        ready0 = 1'b1;
        #1;
        chk({nm, "_drain_busy"}, 32'(busy0), 1);
        chk({nm, "_drain_rden"}, 32'(ref_rden0), 0);
        while (!done0 && c < 1000) begin
            tick();
            c++;
        end
        chk({nm, "_done_time"}, c, exp_done);
        chk({nm, "_done_busy"}, 32'(busy0), 0);
        if (hold_start) begin
            repeat (3) tick();
            chk({nm, "_hold_done"}, 32'(done0), 1);
            chk({nm, "_no_rerun_rden"}, 32'(ref_rden0), 0);
            chk({nm, "_no_rerun_busy"}, 32'(busy0), 0);
            start0 = 1'b0;
            tick();
            chk({nm, "_back_idle"}, 32'(done0), 0);
        end else begin
            tick();
            chk({nm, "_idle_done"}, 32'(done0), 0);
            chk({nm, "_idle_busy"}, 32'(busy0), 0);
        end
    endtask

    initial begin
        int k;
        int c;

        // Reset state
        repeat (2) tick();
        chk("rst_pv", 32'(pair_valid0), 0);
        chk("rst_last", 32'(pair_last_nb0), 0);
        chk("rst_id", 32'(pair_ref_id0), 0);
        chk("rst_rden", 32'(ref_rden0 | nb_rden0), 0);
        chk("rst_addr", 32'({ref_addr0, nb_addr0}), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        tick();

        // 1: held start, no stalls; 2: stall in READ cycles 5..9
        run_sweep0("c1", -1, -2, -1, 1'b1, 114);
        run_sweep0("c2", 5, 9, -1, 1'b0, 119);
        // 3: reset on the (3,6) read, then a full restart
        run_sweep0("c3a", -1, -2, 36, 1'b0, 0);
        run_sweep0("c3b", -1, -2, -1, 1'b0, 114);
        // 4: single-cycle start pulse
        run_sweep0("c4", -1, -2, -1, 1'b0, 114);

        // 5: 1x1 sweep, latency 1
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        #1;
        chk("c5_rden", 32'(ref_rden1 & nb_rden1), 1);
        chk("c5_addr", 32'({ref_addr1, nb_addr1}), 0);
        tick();
        chk("c5_pv", 32'(pair_valid1), 1);
        chk("c5_last", 32'(pair_last_nb1), 1);
        chk("c5_id", 32'(pair_ref_id1), 0);
        chk("c5_drain_rden", 32'(ref_rden1), 0);
        chk("c5_drain_busy", 32'(busy1), 1);
        chk("c5_drain_done", 32'(done1), 0);
        tick();
        chk("c5_done", 32'(done1), 1);
        chk("c5_done_pv", 32'(pair_valid1), 0);
        tick();
        chk("c5_idle", 32'(done1), 0);

        // 6: 10x3 sweep, pipe_ready toggling every cycle
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 0;
        c = 0;
        while (k < 30 && c < 200) begin
            ready2 = (c % 2 == 0) ? 1'b1 : 1'b0;
            #1;
            chk("c6_rden", 32'(ref_rden2), 32'(ready2));
            chk("c6_ref_addr", 32'(ref_addr2), k / 3);
            chk("c6_nb_addr", 32'(nb_addr2), k % 3);
            tick();
            c++;
            chk("c6_pv", 32'(pair_valid2), 32'(ready2));
            if (ready2) begin
                chk("c6_id", 32'(pair_ref_id2), k / 3);
                chk("c6_last", 32'(pair_last_nb2), (k % 3 == 2) ? 1 : 0);
                k++;
            end
        end
        chk("c6_pair_count", k, 30);
        ready2 = 1'b1;
        while (!done2 && c < 300) begin
            tick();
            c++;
        end
        chk("c6_done_time", c, 73);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
